muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for RV32 M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_seq_pkg.sv | 38 +++
 rtl/muldiv_div_step.sv | 37 +++
 rtl/muldiv_seq.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// ============================================================================
//  Module   : muldiv_seq_pkg
//  Purpose  : Shared RV32 M-extension decode constants and sequencer state
//             encodings for muldiv_seq and its sub-modules.
//  Contents : OPCODE_OP / FUNCT7_MULDIV decode values, funct3 op codes,
//             FSM state encodings, is-M decode helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_seq_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_MUL  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DIV  = 3'd2;
    localparam logic [STATE_W-1:0] ST_FIX  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

    function automatic logic f_is_m(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_step.sv
// ============================================================================
//  Module   : muldiv_div_step
//  Purpose  : One combinational restoring-division step on magnitudes.
//  Ports    : i_remquo  {partial remainder, quotient/dividend shift reg}
//             i_divisor divisor magnitude
//             o_remquo  {remainder, quotient} after one step
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_div_step
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_remquo,
    input  logic [XLEN-1:0]   i_divisor,
    output logic [2*XLEN-1:0] o_remquo
);

    // Remainder shifted left with the next dividend bit; it stays below
    // 2*divisor, so one extra bit is enough to hold it.
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [XLEN-2:0] w_quo_low;

    assign w_shift   = {i_remquo[2*XLEN-1:XLEN], i_remquo[XLEN-1]};
    assign w_trial   = w_shift - {1'b0, i_divisor};
    assign w_quo_low = i_remquo[XLEN-2:0];

    // Negative trial means the divisor did not fit: restore and shift in 0.
    assign o_remquo = w_trial[XLEN] ? {w_shift[XLEN-1:0], w_quo_low, 1'b0}
                                    : {w_trial[XLEN-1:0], w_quo_low, 1'b1};

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Multi-cycle sequencer for RV32 M ops. Single-cycle multiply,
//             XLEN-step restoring divide, valid/ready result return.
//  Ports    : clk, rst (sync, active-high), flush (kill in-flight op)
//             in_valid/in_ready + opcode/funct3/funct7/rd/rs1_val/rs2_val
//             out_valid/out_ready + out_result/out_rd
//             busy (sequencer not idle)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            busy
);

    localparam int                 CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]    INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [2:0]         r_f3;
    logic [4:0]         r_out_rd;
    logic [XLEN-1:0]    r_result;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [CNT_W-1:0]   r_cnt;

    // ---------------- accept-time decode ----------------
    logic            w_is_m;
    logic            w_accept;
    logic            w_signed_div;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_div_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;

    assign in_ready     = (r_state == ST_IDLE) && !flush;
    assign w_is_m       = f_is_m(opcode, funct7);
    assign w_accept     = in_valid && in_ready && w_is_m;
    assign w_signed_div = !funct3[0];
    assign w_div_zero   = (rs2_val == '0);
    assign w_div_ovf    = w_signed_div && (rs1_val == INT_MIN) && (rs2_val == '1);
    assign w_div_special = funct3[2] && (w_div_zero || w_div_ovf);

    // Divide-by-zero: quotient all-ones, remainder = dividend.
    // Signed overflow: quotient = dividend (INT_MIN), remainder 0.
    assign w_special_res = w_div_zero ? (funct3[1] ? rs1_val : '1)
                                      : (funct3[1] ? '0 : rs1_val);

    assign w_abs_a = (w_signed_div && rs1_val[XLEN-1]) ? (~rs1_val + 1'b1) : rs1_val;
    assign w_abs_b = (w_signed_div && rs2_val[XLEN-1]) ? (~rs2_val + 1'b1) : rs2_val;

    // ---------------- multiply ----------------
    // Operands are extended to 2*XLEN per op signedness; the wrapped
    // 2*XLEN-bit product then carries the correct high and low halves.
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_a_sgn   = (r_f3 == F3_MULH) || (r_f3 == F3_MULHSU);
    assign w_b_sgn   = (r_f3 == F3_MULH);
    assign w_a_ext   = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
    assign w_b_ext   = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // ---------------- divide ----------------
    logic [2*XLEN-1:0] w_step;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    muldiv_div_step #(
        .XLEN      (XLEN)
    ) u_div_step (
        .i_remquo  ({r_rem, r_quo}),
        .i_divisor (r_divisor),
        .o_remquo  (w_step)
    );

    assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!funct3[2])         w_next_state = ST_MUL;
                        else if (w_div_special) w_next_state = ST_DONE;
                        else                    w_next_state = ST_DIV;
                    end
                end
                ST_MUL:  w_next_state = ST_DONE;
                ST_DIV:  if (r_cnt == CNT_LAST) w_next_state = ST_FIX;
                ST_FIX:  w_next_state = ST_DONE;
                ST_DONE: if (out_ready) w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_f3      <= '0;
            r_out_rd  <= '0;
            r_result  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a       <= rs1_val;
                        r_b       <= rs2_val;
                        r_f3      <= funct3;
                        r_out_rd  <= rd;
                        r_rem     <= '0;
                        r_quo     <= w_abs_a;
                        r_divisor <= w_abs_b;
                        r_neg_q   <= w_signed_div && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                        r_neg_r   <= w_signed_div && rs1_val[XLEN-1];
                        r_cnt     <= '0;
                        if (w_div_special) r_result <= w_special_res;
                    end
                end
                ST_MUL: r_result <= w_mul_res;
                ST_DIV: begin
                    r_rem <= w_step[2*XLEN-1:XLEN];
                    r_quo <= w_step[XLEN-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: r_result <= r_f3[1] ? w_r_fix : w_q_fix;
                default: ;
            endcase
        end
    end

    assign out_valid  = (r_state == ST_DONE);
    assign out_result = r_result;
    assign out_rd     = r_out_rd;
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Self-checking bench for muldiv_seq: behavioural reference
//             model, per-cycle compare process, directed and random ops.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .rd         (rd),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got no event within bound, expected event", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint p;
        int     ia = a;
        int     ib = b;
        bit     ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        logic [31:0] r;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_rd = '0;
    bit          m_exp_valid;
    bit          seen = 1'b0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;
    int          last_lat = -1;

    // One compare process: outputs checked each cycle, model advanced for
    // the coming edge from the inputs that will be sampled there.
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_busy) m_age++;
            m_exp_valid = m_busy && (m_age >= m_lat);
            chk("out_valid", 32'(out_valid), 32'(m_exp_valid));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("in_ready", 32'(in_ready), 32'(!m_busy && !flush));
            if (m_exp_valid) begin
                chk("out_result", out_result, m_res);
                chk("out_rd", 32'(out_rd), 32'(m_rd));
            end
            if (m_busy && out_valid && !seen) begin
                seen     = 1'b1;
                last_lat = m_age;
                last_res = out_result;
                last_rd  = out_rd;
            end
            if (rst || flush) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_exp_valid && out_ready) begin
                    m_busy = 1'b0;
                    done_cnt++;
                end
            end else if (in_valid && opcode == 7'h33 && funct7 == 7'h01) begin
                m_busy   = 1'b1;
                m_age    = 0;
                m_lat    = model_lat(funct3, rs1_val, rs2_val);
                m_res    = model_res(funct3, rs1_val, rs2_val);
                m_rd     = rd;
                seen     = 1'b0;
                last_lat = -1;
                acc_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        opcode   = 7'h33;
        funct7   = 7'h01;
        funct3   = f3;
        rs1_val  = a;
        rs2_val  = b;
        rd       = r;
        in_valid = 1'b1;
    endtask

    task automatic wait_acc(input int start);
        int k = 0;
        while (acc_cnt == start && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (acc_cnt == start) fail_timeout("accept");
    endtask

    task automatic wait_done(input int start, input bit rnd_ready);
        int k = 0;
        while (done_cnt == start && k < 200) begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            k++;
        end
        out_ready = 1'b1;
        if (done_cnt == start) fail_timeout("complete");
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input bit rnd_ready);
        int a0 = acc_cnt;
        int d0 = done_cnt;
        issue(f3, a, b, r);
        wait_acc(a0);
        in_valid = 1'b0;
        wait_done(d0, rnd_ready);
    endtask

    task automatic directed(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r,
                            input logic [31:0] exp_res, input int exp_lat);
        run_op(f3, a, b, r, 1'b0);
        chk({name, "_res"}, last_res, exp_res);
        chk({name, "_lat"}, 32'(last_lat), 32'(exp_lat));
        chk({name, "_rd"}, 32'(last_rd), 32'(r));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 20));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin
        int a0;
        int d0;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // multiply
        directed("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2);
        directed("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 2);
        directed("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 2);
        directed("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 2);
        // divide
        directed("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 34);
        directed("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 34);
        directed("divu",   3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        34);
        directed("remu",   3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         34);
        // special cases
        directed("divu0",  3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1);
        directed("rem0",   3'd6, 32'd5,         32'd0,         5'd14, 32'd5,         1);
        directed("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
        directed("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0,         1);
        directed("rd0",    3'd0, 32'd3,         32'd4,         5'd0,  32'd12,        2);

        // back-pressure: result held 5 cycles, next op queued behind it
        out_ready = 1'b0;
        a0 = acc_cnt;
        issue(3'd0, 32'd3, 32'd5, 5'd9);
        wait_acc(a0);
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
        a0 = acc_cnt;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("stall_acc", 32'(acc_cnt), 32'(a0));
        chk("stall_res", last_res, 32'd15);
        out_ready = 1'b1;
        d0 = done_cnt;
        wait_acc(a0);
        in_valid = 1'b0;
        chk("handoff_done", 32'(done_cnt), 32'(d0 + 1));
        wait_done(done_cnt, 1'b0);
        chk("after_stall_res", last_res, 32'h0B00_EA4E);

        // flush mid-divide
        a0 = acc_cnt;
        d0 = done_cnt;
        issue(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd20);
        wait_acc(a0);
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("flush_no_result", 32'(done_cnt), 32'(d0));

        // non-M instruction is never consumed
        a0 = acc_cnt;
        opcode = 7'h33; funct7 = 7'h00; funct3 = 3'd0; rd = 5'd3; in_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("non_m_acc", 32'(acc_cnt), 32'(a0));

        // reset during a multiply
        a0 = acc_cnt;
        issue(3'd0, 32'd6, 32'd7, 5'd21);
        wait_acc(a0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_result", out_result, 32'h0);
        chk("rstmid_rd", 32'(out_rd), 32'h0);
        chk("rstmid_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // randomized ops against the model
        for (int i = 0; i < 200; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
